// File: rtl/output_p4_interface_if.sv
// AXI4-Stream bundle shared by the per-VLAN pipeline outputs and the merged
// output toward the queues. The master drives payload and valid, the slave
// drives ready.
interface output_p4_interface_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tkeep, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/output_p4_interface.sv
// Merges the four per-VLAN P4 pipeline output streams into one AXI4-Stream.
// Arbitration is packet-atomic round-robin: a granted slot keeps the grant
// until its tlast beat is accepted, then one idle cycle re-arbitrates.
// A 2-entry FIFO (head/tail registers) sits between the selected slot and
// the output, so downstream backpressure never reaches the pipelines
// combinationally. Slot readiness depends only on the registered FIFO count.
module output_p4_interface #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_SLOTS            = 4,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                   axis_aclk,
    input  logic                   axis_resetn,
    output_p4_interface_if.slave   s_axis_0,
    output_p4_interface_if.slave   s_axis_1,
    output_p4_interface_if.slave   s_axis_2,
    output_p4_interface_if.slave   s_axis_3,
    output_p4_interface_if.master  m_axis,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_1,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_2,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_3
);

    localparam int KEEP_WIDTH = C_M_AXIS_DATA_WIDTH / 8;
    localparam int BEAT_WIDTH = C_M_AXIS_DATA_WIDTH + KEEP_WIDTH + C_M_AXIS_TUSER_WIDTH + 1;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic [NUM_SLOTS-1:0]              slot_valid;
    logic [NUM_SLOTS-1:0]              slot_last;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    slot_data [NUM_SLOTS];
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  slot_keep [NUM_SLOTS];
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   slot_user [NUM_SLOTS];

    logic                  arb_found;
    logic [1:0]            arb_sel;
    logic [1:0]            arb_idx;

    logic [BEAT_WIDTH-1:0] head_q;
    logic [BEAT_WIDTH-1:0] tail_q;
    logic [1:0]            fifo_count_q;

    logic                  xfer_ready;
    logic                  push;
    logic                  push_last;
    logic                  pop;
    logic [BEAT_WIDTH-1:0] in_beat;

    logic [CNT_WIDTH-1:0]  pkt_cnt_0_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_1_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_2_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_3_q;

    assign slot_valid = {s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
    assign slot_last  = {s_axis_3.tlast,  s_axis_2.tlast,  s_axis_1.tlast,  s_axis_0.tlast};

    assign slot_data[0] = s_axis_0.tdata;
    assign slot_data[1] = s_axis_1.tdata;
    assign slot_data[2] = s_axis_2.tdata;
    assign slot_data[3] = s_axis_3.tdata;
    assign slot_keep[0] = s_axis_0.tkeep;
    assign slot_keep[1] = s_axis_1.tkeep;
    assign slot_keep[2] = s_axis_2.tkeep;
    assign slot_keep[3] = s_axis_3.tkeep;
    assign slot_user[0] = s_axis_0.tuser;
    assign slot_user[1] = s_axis_1.tuser;
    assign slot_user[2] = s_axis_2.tuser;
    assign slot_user[3] = s_axis_3.tuser;

    assign xfer_ready = (state_q == XFER) && (fifo_count_q < 2'd2);
    assign push       = xfer_ready && slot_valid[grant_q];
    assign push_last  = push && slot_last[grant_q];
    assign pop        = (fifo_count_q != 2'd0) && m_axis.tready;
    assign in_beat    = {slot_data[grant_q], slot_keep[grant_q], slot_user[grant_q], slot_last[grant_q]};

    assign s_axis_0.tready = xfer_ready && (grant_q == 2'd0);
    assign s_axis_1.tready = xfer_ready && (grant_q == 2'd1);
    assign s_axis_2.tready = xfer_ready && (grant_q == 2'd2);
    assign s_axis_3.tready = xfer_ready && (grant_q == 2'd3);

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tuser, m_axis.tlast} = head_q;
    assign m_axis.tvalid = (fifo_count_q != 2'd0);

    assign pkt_cnt_0 = pkt_cnt_0_q;
    assign pkt_cnt_1 = pkt_cnt_1_q;
    assign pkt_cnt_2 = pkt_cnt_2_q;
    assign pkt_cnt_3 = pkt_cnt_3_q;

    // Round-robin search: first valid slot after the last one served.
    always_comb begin
        arb_found = 1'b0;
        arb_sel   = last_grant_q;
        arb_idx   = last_grant_q;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            arb_idx = last_grant_q + 2'(i);
            if (!arb_found && slot_valid[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = arb_idx;
            end
        end
    end

    // Next-state logic: grant on any valid slot, release after the tlast beat.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_sel;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (push_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Two-entry FIFO: head drives the output and keeps its value once drained.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            head_q       <= '0;
            tail_q       <= '0;
            fifo_count_q <= 2'd0;
        end else begin
            case (fifo_count_q)
                2'd0: begin
                    if (push) head_q <= in_beat;
                end
                2'd1: begin
                    if (push && pop) head_q <= in_beat;
                    else if (push)   tail_q <= in_beat;
                end
                2'd2: begin
                    if (pop) head_q <= tail_q;
                end
                default: ;
            endcase
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: ;
            endcase
        end
    end

    // Per-slot packet counters, bumped when a packet's tlast beat is accepted.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            pkt_cnt_0_q <= '0;
            pkt_cnt_1_q <= '0;
            pkt_cnt_2_q <= '0;
            pkt_cnt_3_q <= '0;
        end else if (push_last) begin
            case (grant_q)
                2'd0:    pkt_cnt_0_q <= pkt_cnt_0_q + 1'b1;
                2'd1:    pkt_cnt_1_q <= pkt_cnt_1_q + 1'b1;
                2'd2:    pkt_cnt_2_q <= pkt_cnt_2_q + 1'b1;
                default: pkt_cnt_3_q <= pkt_cnt_3_q + 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_output_p4_interface.sv
// Directed bench for output_p4_interface: per-slot source queues, a sink that
// records accepted beats with their cycle numbers, and hand-ordered expected
// streams for each scenario.
module tb_output_p4_interface;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic axis_aclk = 1'b0;
    logic axis_resetn;
    logic sink_ready;
    int   cyc;
    int   checks;
    int   errors;

    logic         src_valid [4];
    logic         src_last  [4];
    logic [255:0] src_data  [4];
    logic [31:0]  src_keep  [4];
    logic [127:0] src_user  [4];
    logic [3:0]   src_rdy;

    logic [31:0] pkt_cnt_0, pkt_cnt_1, pkt_cnt_2, pkt_cnt_3;

    beat_t src_q [4][$];
    beat_t exp_q [$];
    beat_t recv_q [$];
    int    recv_cyc [$];

    output_p4_interface_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if0 ();
    output_p4_interface_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if1 ();
    output_p4_interface_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if2 ();
    output_p4_interface_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) s_if3 ();
    output_p4_interface_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) m_if ();

    assign s_if0.tvalid = src_valid[0];
    assign s_if0.tlast  = src_last[0];
    assign s_if0.tdata  = src_data[0];
    assign s_if0.tkeep  = src_keep[0];
    assign s_if0.tuser  = src_user[0];
    assign s_if1.tvalid = src_valid[1];
    assign s_if1.tlast  = src_last[1];
    assign s_if1.tdata  = src_data[1];
    assign s_if1.tkeep  = src_keep[1];
    assign s_if1.tuser  = src_user[1];
    assign s_if2.tvalid = src_valid[2];
    assign s_if2.tlast  = src_last[2];
    assign s_if2.tdata  = src_data[2];
    assign s_if2.tkeep  = src_keep[2];
    assign s_if2.tuser  = src_user[2];
    assign s_if3.tvalid = src_valid[3];
    assign s_if3.tlast  = src_last[3];
    assign s_if3.tdata  = src_data[3];
    assign s_if3.tkeep  = src_keep[3];
    assign s_if3.tuser  = src_user[3];
    assign src_rdy      = {s_if3.tready, s_if2.tready, s_if1.tready, s_if0.tready};
    assign m_if.tready  = sink_ready;

    output_p4_interface dut (
        .axis_aclk   (axis_aclk),
        .axis_resetn (axis_resetn),
        .s_axis_0    (s_if0),
        .s_axis_1    (s_if1),
        .s_axis_2    (s_if2),
        .s_axis_3    (s_if3),
        .m_axis      (m_if),
        .pkt_cnt_0   (pkt_cnt_0),
        .pkt_cnt_1   (pkt_cnt_1),
        .pkt_cnt_2   (pkt_cnt_2),
        .pkt_cnt_3   (pkt_cnt_3)
    );

    always #5 axis_aclk = ~axis_aclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic beat_t mkBeat(input int slot, input int pkt, input int idx, input logic last);
        beat_t b;
        logic [7:0] v;
        v      = {slot[1:0], pkt[2:0], idx[2:0]};
        b.data = {32{v}} ^ {8{32'hDEAD_BEEF}};
        b.keep = {4{~v}};
        b.user = {16{v ^ 8'h5A}};
        b.last = last;
        return b;
    endfunction

    // Queue one packet on a source slot.
    task automatic applyStimulus(input int slot, input int pkt, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            src_q[slot].push_back(mkBeat(slot, pkt, i, (i == nbeats - 1)));
    endtask

    // Append one packet to the expected output stream.
    task automatic expectPacket(input int slot, input int pkt, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            exp_q.push_back(mkBeat(slot, pkt, i, (i == nbeats - 1)));
    endtask

    // One clock: record the sink handshake at the negedge, then advance sources after the edge.
    task automatic tick();
        logic [3:0] take;
        beat_t      b;
        @(negedge axis_aclk);
        for (int s = 0; s < 4; s++) take[s] = src_valid[s] && src_rdy[s];
        if (axis_resetn && m_if.tvalid && sink_ready) begin
            b.data = m_if.tdata;
            b.keep = m_if.tkeep;
            b.user = m_if.tuser;
            b.last = m_if.tlast;
            recv_q.push_back(b);
            recv_cyc.push_back(cyc);
        end
        @(posedge axis_aclk);
        cyc++;
        #1;
        for (int s = 0; s < 4; s++) begin
            if (take[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            if (src_q[s].size() > 0) begin
                src_valid[s] = 1'b1;
                src_data[s]  = src_q[s][0].data;
                src_keep[s]  = src_q[s][0].keep;
                src_user[s]  = src_q[s][0].user;
                src_last[s]  = src_q[s][0].last;
            end else begin
                src_valid[s] = 1'b0;
            end
        end
    endtask

    task automatic runUntilDone(input int budget);
        int n = 0;
        while (recv_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_count"}, recv_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++)
            checkOutput($sformatf("%s_beat%0d", tag, i), recv_q[i], exp_q[i]);
    endtask

    task automatic clearStreams();
        exp_q.delete();
        recv_q.delete();
        recv_cyc.delete();
    endtask

    task automatic checkCounters(input string tag, input int c0, input int c1, input int c2, input int c3);
        checkOutput({tag, "_cnt0"}, pkt_cnt_0, 32'(c0));
        checkOutput({tag, "_cnt1"}, pkt_cnt_1, 32'(c1));
        checkOutput({tag, "_cnt2"}, pkt_cnt_2, 32'(c2));
        checkOutput({tag, "_cnt3"}, pkt_cnt_3, 32'(c3));
    endtask

    task automatic checkQuietOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, m_if.tvalid, 1'b0);
        checkOutput({tag, "_payload"}, {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}, '0);
        checkOutput({tag, "_sready"}, src_rdy, 4'b0000);
    endtask

    initial begin
        int c_start;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        sink_ready  = 1'b1;
        axis_resetn = 1'b0;
        for (int s = 0; s < 4; s++) begin
            src_valid[s] = 1'b0;
            src_last[s]  = 1'b0;
            src_data[s]  = '0;
            src_keep[s]  = '0;
            src_user[s]  = '0;
        end

        $display("[TB] reset");
        repeat (3) tick();
        checkQuietOutputs("reset");
        checkCounters("reset", 0, 0, 0, 0);
        axis_resetn = 1'b1;
        tick();

        $display("[TB] four slots, one 2-beat packet each");
        clearStreams();
        for (int s = 0; s < 4; s++) applyStimulus(s, 0, 2);
        for (int s = 0; s < 4; s++) expectPacket(s, 0, 2);
        runUntilDone(80);
        checkStream("rr4");
        if (recv_cyc.size() == 8) begin
            for (int k = 1; k < 4; k++)
                checkOutput($sformatf("rr4_gap%0d", k), recv_cyc[2*k] - recv_cyc[2*k-1], 2);
            checkOutput("rr4_b2b", recv_cyc[1] - recv_cyc[0], 1);
        end
        checkCounters("rr4", 1, 1, 1, 1);

        $display("[TB] slots 1 and 3 alternate");
        clearStreams();
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1, p, 2);
            applyStimulus(3, p, 2);
        end
        for (int p = 0; p < 4; p++) begin
            expectPacket(1, p, 2);
            expectPacket(3, p, 2);
        end
        runUntilDone(120);
        checkStream("alt");
        checkCounters("alt", 1, 5, 1, 5);

        $display("[TB] single 3-beat packet on slot 2");
        clearStreams();
        c_start = cyc;
        applyStimulus(2, 5, 3);
        expectPacket(2, 5, 3);
        runUntilDone(40);
        checkStream("single");
        if (recv_cyc.size() > 0) checkOutput("single_latency", recv_cyc[0] - c_start, 3);
        checkCounters("single", 1, 5, 2, 5);

        $display("[TB] downstream stall during a 5-beat packet");
        clearStreams();
        applyStimulus(1, 6, 5);
        expectPacket(1, 6, 5);
        begin
            int n = 0;
            while (!m_if.tvalid && n < 20) begin
                tick();
                n++;
            end
        end
        checkOutput("stall_first_valid", m_if.tvalid, 1'b1);
        tick();
        sink_ready = 1'b0;
        checkOutput("stall1_tvalid", m_if.tvalid, 1'b1);
        checkOutput("stall1_sready", src_rdy[1], 1'b1);
        tick();
        checkOutput("stall2_tvalid", m_if.tvalid, 1'b1);
        checkOutput("stall2_sready_full", src_rdy[1], 1'b0);
        tick();
        sink_ready = 1'b1;
        runUntilDone(40);
        checkStream("stall");
        checkCounters("stall", 1, 6, 2, 5);

        $display("[TB] reset pulse mid-packet on slot 0");
        clearStreams();
        applyStimulus(0, 7, 6);
        begin
            int n = 0;
            while (recv_q.size() < 2 && n < 20) begin
                tick();
                n++;
            end
        end
        checkOutput("rst_partial_seen", recv_q.size() >= 2, 1'b1);
        axis_resetn = 1'b0;
        src_q[0].delete();
        src_valid[0] = 1'b0;
        #1;
        checkQuietOutputs("rst_pulse");
        checkCounters("rst_pulse", 0, 0, 0, 0);
        tick();
        axis_resetn = 1'b1;
        clearStreams();
        repeat (3) tick();
        checkOutput("rst_after_tvalid", m_if.tvalid, 1'b0);
        checkOutput("rst_after_nobeats", recv_q.size(), 0);
        applyStimulus(0, 1, 4);
        expectPacket(0, 1, 4);
        runUntilDone(40);
        checkStream("rst_next");
        checkCounters("rst_next", 1, 0, 0, 0);

        $display("[TB] counter wrap on slot 0");
        clearStreams();
        force dut.pkt_cnt_0_q = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt_0_q;
        tick();
        checkOutput("wrap_preset", pkt_cnt_0, 32'hFFFF_FFFF);
        applyStimulus(0, 2, 2);
        expectPacket(0, 2, 2);
        runUntilDone(40);
        checkStream("wrap");
        checkCounters("wrap", 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_p4_interface.md
Name: output_p4_interface

Overview:
- Merges the four per-VLAN P4 pipeline output streams (slots 0..3, VLAN IDs 1..4) into a single AXI4-Stream toward the output queues.
- Opposite end of the input VLAN demultiplexer.
- Arbitration is packet-atomic round-robin: once a slot is granted, its whole packet (through tlast) goes out before another slot is served.
- A 2-entry output FIFO decouples downstream backpressure from the selected upstream pipeline.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width.
- C_S_AXIS_DATA_WIDTH, 256, input tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- NUM_SLOTS, 4, number of input streams; fixed at 4 in this revision.
- CNT_WIDTH, 32, width of the per-slot packet counters.

Ports:
- axis_aclk  in  1  clock; all logic in this domain.
- axis_resetn  in  1  reset, asynchronous, active-low.
- s_axis_N_tdata  in  256  slot N data (N = 0..3; this applies to every s_axis_N_* port).
- s_axis_N_tkeep  in  32  slot N byte enables.
- s_axis_N_tuser  in  128  slot N sideband, passed through unmodified.
- s_axis_N_tvalid  in  1  slot N valid.
- s_axis_N_tlast  in  1  slot N end of packet.
- s_axis_N_tready  out  1  slot N ready.
- m_axis_tdata  out  256  merged data.
- m_axis_tkeep  out  32  merged byte enables.
- m_axis_tuser  out  128  merged sideband.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged end of packet.
- m_axis_tready  in  1  downstream ready.
- pkt_cnt_N  out  32  packets forwarded from slot N.

Behaviour:
- Reset (async assert, sync deassert on axis_aclk):
  - state = IDLE, grant = 0, last_grant = 3, FIFO empty.
  - All s_axis_N_tready = 0; m_axis_tvalid = 0; m_axis_tdata/tkeep/tuser/tlast = 0.
  - pkt_cnt_N = 0.
- Reset mid-packet: the partial packet is discarded and the FIFO is flushed. No beat is emitted after reset deasserts until a new arbitration completes.
- State IDLE:
  - All s_axis_N_tready = 0.
  - If any s_axis_N_tvalid = 1: grant <= first valid slot searching last_grant+1, last_grant+2, ... (mod 4); go to XFER. Otherwise stay in IDLE.
  - Arbitration costs one cycle.
- State XFER:
  - s_axis_grant_tready = 1 iff FIFO count < 2, evaluated on registered count only. All non-granted readies = 0.
  - A beat is accepted when the granted slot has tvalid & tready. The beat is pushed as {tdata, tkeep, tuser, tlast}.
  - Accepted beat with tlast = 1: last_grant <= grant; pkt_cnt_grant increments (wraps 2^32-1 -> 0); next state IDLE.
  - Back-to-back packets therefore carry one idle input cycle between them.
- Output FIFO (2 entries):
  - m_axis_* is driven from the FIFO head; m_axis_tvalid = (count != 0).
  - Pop on m_axis_tvalid & m_axis_tready.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - When empty, m_axis_tdata/tkeep/tuser/tlast hold their last values; consumers must ignore them while tvalid = 0.
- Latency: a beat accepted at cycle t is visible on m_axis at t+1 if the FIFO was empty. Full throughput, 1 beat/cycle, is sustained while m_axis_tready = 1.
- Packet contents are never altered. tkeep and tuser pass through bit-exact, including any VLAN tag.
- Slots with tvalid = 0 are never granted. A granted slot that drops tvalid mid-packet keeps the grant; no timeout.
- m_axis_tvalid, once asserted, is not deasserted until the beat is accepted (AXIS compliance).

Test Plan:
- Single 3-beat packet on slot 2, m_axis_tready = 1 -> 3 beats on m_axis in order; tlast on beat 3; pkt_cnt_2 = 1; others 0.
- Slots 0..3 each hold one 2-beat packet at the same time -> output order 0,1,2,3. Packets are never interleaved; 1 idle input cycle between packets.
- Slots 1 and 3 continuously valid, 4 packets each -> strict alternation 1,3,1,3,... with last_grant honoured.
- m_axis_tready toggled 1,0,0,1 during a 5-beat packet -> no beat lost or duplicated. Slot tready drops only when FIFO holds 2 beats; m_axis_tvalid stays high while stalled.
- axis_resetn pulsed low for 1 cycle mid-packet on slot 0 -> all outputs immediately 0, counters 0. The next full packet on slot 0 forwards correctly.
- pkt_cnt_0 forced near wrap (0xFFFFFFFF), one packet sent -> pkt_cnt_0 = 0.
